cache_fill_fsm: RTL and testbench

//  Miss-handling engine between the CPU's cache arrays and the multi-cycle main memory.
//  On a cache miss it fetches the whole 16-byte block (8 x 16-bit words) from main memory.
//  It writes each returned word into the data array, then commits the tag.
//  fsm_busy stalls the pipeline for the whole fill; the same block serves the I-cache and the D-cache.

---
 rtl/cache_fill_fsm.sv | 146 ++++++++++++++
 tb/tb_cache_fill_fsm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling engine shared by the I-cache and the D-cache.
// On a miss it fetches the whole block from multi-cycle main memory. Reads are
// issued one per cycle, and the memory is pipelined with no backpressure. Each
// returned word is written into the data array. The tag is committed in the
// same cycle as the final data write.
// Optional feature: define CACHE_FILL_CRITICAL_FIRST_EN to start both the read
// issue and the data-array writes at the missed word, wrapping within the block.
// Without it, every fill runs in order from word 0.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int OFF_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [OFF_W-1:0]  data_array_word,
  output logic [DATA_W-1:0] data_array_data,
  output logic              write_tag_array
);

  // The issue counter needs one extra bit so it can hold "all words issued".
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST_PLUS1 = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [OFF_W-1:0]  WORD_LAST      = OFF_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLOCK_MASK     = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [OFF_W-1:0]  recv_cnt_reg, recv_cnt_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [OFF_W-1:0]  off0_reg, off0_next;

  // Word offset at which this miss starts the fill.
  logic [OFF_W-1:0]  miss_off0;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  assign miss_off0 = miss_address[OFF_W:1];
`else
  assign miss_off0 = '0;
`endif

  // Issue-side address generation. After the last request, the index is pinned
  // at the final word, so memory_address keeps its last issued value.
  logic              issuing;
  logic [OFF_W-1:0]  issue_idx;
  logic [OFF_W-1:0]  issue_word;
  logic [ADDR_W-1:0] issue_addr;

  assign issuing    = (issue_cnt_reg < CNT_LAST_PLUS1);
  assign issue_idx  = issuing ? issue_cnt_reg[OFF_W-1:0] : WORD_LAST;
  assign issue_word = off0_reg + issue_idx;  // wraps modulo block size
  assign issue_addr = base_reg + ADDR_W'({issue_word, 1'b0});

  // State register and fill bookkeeping; reset abandons any partial fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
      base_reg      <= '0;
      off0_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
      base_reg      <= base_next;
      off0_reg      <= off0_next;
    end
  end

  // Next-state logic. The issue and receive counters advance independently.
  always_comb begin
    state_next     = state_reg;
    issue_cnt_next = issue_cnt_reg;
    recv_cnt_next  = recv_cnt_reg;
    base_next      = base_reg;
    off0_next      = off0_reg;
    unique case (state_reg)
      IDLE: begin
        if (miss_detected) begin
          state_next     = FILL;
          base_next      = miss_address & ~BLOCK_MASK;
          off0_next      = miss_off0;
          issue_cnt_next = '0;
          recv_cnt_next  = '0;
        end
      end
      FILL: begin
        if (issuing) begin
          issue_cnt_next = issue_cnt_reg + CNT_W'(1);
        end
        if (memory_data_valid) begin
          if (recv_cnt_reg == WORD_LAST) begin
            state_next     = IDLE;
            issue_cnt_next = '0;
            recv_cnt_next  = '0;
          end else begin
            recv_cnt_next  = recv_cnt_reg + OFF_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode. The stall is raised combinationally in the miss cycle, and
  // it is masked while rst is high so every output reads 0 during reset.
  always_comb begin
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_array_word  = '0;
    data_array_data  = '0;
    write_tag_array  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        fsm_busy = miss_detected & ~rst;
      end
      FILL: begin
        fsm_busy         = 1'b1;
        memory_read      = issuing;
        memory_address   = issue_addr;
        write_data_array = memory_data_valid;
        data_array_word  = off0_reg + recv_cnt_reg;
        data_array_data  = memory_data;
        write_tag_array  = memory_data_valid & (recv_cnt_reg == WORD_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Testbench for cache_fill_fsm.
// - A table of per-cycle vectors covers a latency-4 fill, then a back-to-back
//   miss.
// - Hand-written sequences cover async reset, gapped returns, reset mid-fill,
//   the top-of-memory block, and (when CACHE_FILL_CRITICAL_FIRST_EN is
//   defined) critical-word-first ordering.
module tb_cache_fill_fsm;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_array_word;
  logic [15:0] data_array_data;
  logic        write_tag_array;

  int checks   = 0;
  int failures = 0;

  cache_fill_fsm #(
    .ADDR_W          (16),
    .DATA_W          (16),
    .WORDS_PER_BLOCK (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_array_word   (data_array_word),
    .data_array_data   (data_array_data),
    .write_tag_array   (write_tag_array)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [15:0] maddr;
    logic        mvalid;
    logic [15:0] mdata;
    logic        busy;
    logic        rd;
    logic [15:0] addr;
    logic        wda;
    logic [2:0]  word;
    logic [15:0] ddata;
    logic        tag;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".busy"}, 32'(fsm_busy), 32'd0);
    chk({nm, ".read"}, 32'(memory_read), 32'd0);
    chk({nm, ".addr"}, 32'(memory_address), 32'd0);
    chk({nm, ".wda"}, 32'(write_data_array), 32'd0);
    chk({nm, ".word"}, 32'(data_array_word), 32'd0);
    chk({nm, ".data"}, 32'(data_array_data), 32'd0);
    chk({nm, ".tag"}, 32'(write_tag_array), 32'd0);
  endtask

  // Drive one miss and serve the fill from a simple pipelined memory model.
  // Latency is lat cycles. Returns are allowed only on cycles where
  // c % period == 0, so period 3 gives a 1,0,0 valid pattern.
  task automatic fill_seq(input logic [15:0] maddr, input logic [15:0] base, input int off0,
                          input int lat, input int period, input bit hold_miss,
                          input string nm);
    logic [15:0] q_addr[$];
    int          q_due[$];
    int          issued = 0;
    int          recv   = 0;
    int          c      = 0;
    int          tags   = 0;
    bit          done   = 0;
    logic [15:0] exp_addr;
    logic [15:0] cur_data;
    int          idx;

    miss_detected     = 1'b1;
    miss_address      = maddr;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    @(negedge clk);
    chk({nm, ".miss_busy"}, 32'(fsm_busy), 32'd1);
    chk({nm, ".miss_read"}, 32'(memory_read), 32'd0);
    @(posedge clk); #1;
    miss_detected = hold_miss;
    c = 1;
    while (!done && c < 200) begin
      if (q_due.size() > 0 && q_due[0] <= c && (c % period) == 0) begin
        cur_data          = q_addr[0] ^ 16'hA5A5;
        memory_data_valid = 1'b1;
        memory_data       = cur_data;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
      end
      @(negedge clk);
      idx      = (issued < 8) ? issued : 7;
      exp_addr = base + 16'(2 * ((off0 + idx) % 8));
      chk($sformatf("%s.c%0d.busy", nm, c), 32'(fsm_busy), 32'd1);
      chk($sformatf("%s.c%0d.read", nm, c), 32'(memory_read), 32'(issued < 8));
      chk($sformatf("%s.c%0d.addr", nm, c), 32'(memory_address), 32'(exp_addr));
      chk($sformatf("%s.c%0d.wda", nm, c), 32'(write_data_array), 32'(memory_data_valid));
      chk($sformatf("%s.c%0d.tag", nm, c), 32'(write_tag_array),
          32'(memory_data_valid && recv == 7));
      if (memory_data_valid) begin
        chk($sformatf("%s.c%0d.word", nm, c), 32'(data_array_word), 32'((off0 + recv) % 8));
        chk($sformatf("%s.c%0d.data", nm, c), 32'(data_array_data), 32'(memory_data));
      end
      if (write_tag_array) tags++;
      if (issued < 8) begin
        q_addr.push_back(exp_addr);
        q_due.push_back(c + lat);
        issued++;
      end
      if (memory_data_valid) begin
        if (recv == 7) done = 1;
        recv++;
      end
      @(posedge clk); #1;
      c++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout: actual=%0d words required=8", nm, recv);
    end
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    @(negedge clk);
    chk({nm, ".after_busy"}, 32'(fsm_busy), 32'd0);
    chk({nm, ".after_read"}, 32'(memory_read), 32'd0);
    chk({nm, ".after_tag"}, 32'(write_tag_array), 32'd0);
    chk({nm, ".tag_count"}, 32'(tags), 32'd1);
    $display("fill %s miss=0x%04h base=0x%04h words=%0d cycles=%0d", nm, maddr, base, recv, c - 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[15];
    int   off;

    // Latency-4 fill of miss 0x1236 (data = addr ^ 0xA5A5), then a
    // back-to-back miss at 0x5554.
    tbl[0]  = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 16'h1236, 1'b1, 16'hB795, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 16'hB795, 1'b0};
    tbl[6]  = '{1'b0, 16'h1236, 1'b1, 16'hB797, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 16'hB797, 1'b0};
    tbl[7]  = '{1'b0, 16'h1236, 1'b1, 16'hB791, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 16'hB791, 1'b0};
    tbl[8]  = '{1'b0, 16'h1236, 1'b1, 16'hB793, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 16'hB793, 1'b0};
    tbl[9]  = '{1'b0, 16'h1236, 1'b1, 16'hB79D, 1'b1, 1'b0, 16'h123E, 1'b1, 3'd4, 16'hB79D, 1'b0};
    tbl[10] = '{1'b0, 16'h1236, 1'b1, 16'hB79F, 1'b1, 1'b0, 16'h123E, 1'b1, 3'd5, 16'hB79F, 1'b0};
    tbl[11] = '{1'b0, 16'h1236, 1'b1, 16'hB799, 1'b1, 1'b0, 16'h123E, 1'b1, 3'd6, 16'hB799, 1'b0};
    tbl[12] = '{1'b0, 16'h1236, 1'b1, 16'hB79B, 1'b1, 1'b0, 16'h123E, 1'b1, 3'd7, 16'hB79B, 1'b1};
    tbl[13] = '{1'b1, 16'h5554, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[14] = '{1'b0, 16'h5554, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h5550, 1'b0, 3'd0, 16'h0000, 1'b0};

    // Reset state: outputs held at 0 while rst is high, even with a miss present.
    rst               = 1'b1;
    miss_detected     = 1'b1;
    miss_address      = 16'h1236;
    memory_data       = 16'hFFFF;
    memory_data_valid = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst               = 1'b0;
    miss_detected     = 1'b0;
    memory_data       = 16'h0;
    memory_data_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");
    @(posedge clk); #1;

`ifndef CACHE_FILL_CRITICAL_FIRST_EN
    // Table-driven in-order fill, one vector per cycle.
    for (int i = 0; i < 15; i++) begin
      miss_detected     = tbl[i].miss;
      miss_address      = tbl[i].maddr;
      memory_data_valid = tbl[i].mvalid;
      memory_data       = tbl[i].mdata;
      @(negedge clk);
      chk($sformatf("tbl[%0d].busy", i), 32'(fsm_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl[%0d].read", i), 32'(memory_read), 32'(tbl[i].rd));
      chk($sformatf("tbl[%0d].addr", i), 32'(memory_address), 32'(tbl[i].addr));
      chk($sformatf("tbl[%0d].wda", i), 32'(write_data_array), 32'(tbl[i].wda));
      chk($sformatf("tbl[%0d].word", i), 32'(data_array_word), 32'(tbl[i].word));
      chk($sformatf("tbl[%0d].data", i), 32'(data_array_data), 32'(tbl[i].ddata));
      chk($sformatf("tbl[%0d].tag", i), 32'(write_tag_array), 32'(tbl[i].tag));
      $display("vec %0d miss=%0b valid=%0b busy=%0b read=%0b addr=0x%04h wda=%0b word=%0d tag=%0b",
               i, tbl[i].miss, tbl[i].mvalid, fsm_busy, memory_read, memory_address,
               write_data_array, data_array_word, write_tag_array);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-cycle during the back-to-back fill.
    miss_detected     = 1'b1;
    memory_data_valid = 1'b1;
    memory_data       = 16'hFFFF;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst               = 1'b0;
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    @(negedge clk);
    chk_all_zero("async_rst_release");
    @(posedge clk); #1;
`endif

    // Gapped returns (valid pattern 1,0,0): busy held, words in order, one tag.
    fill_seq(16'h4000, 16'h4000, 0, 1, 3, 1'b0, "gaps");

    // Reset after 3 data writes: no tag, back to IDLE, clean restart afterwards.
    off = CRIT ? 4 : 0;
    miss_detected     = 1'b1;
    miss_address      = 16'h2468;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    @(posedge clk); #1;
    miss_detected = 1'b0;
    @(negedge clk);
    chk("rstmid.read0", 32'(memory_read), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'h1000 + 16'(k);
      @(negedge clk);
      chk($sformatf("rstmid.w%0d.wda", k), 32'(write_data_array), 32'd1);
      chk($sformatf("rstmid.w%0d.word", k), 32'(data_array_word), 32'((off + k) % 8));
      chk($sformatf("rstmid.w%0d.tag", k), 32'(write_tag_array), 32'd0);
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
    memory_data       = 16'h5A5A;
    miss_detected     = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rstmid.async");
    @(posedge clk); #1;
    rst           = 1'b0;
    miss_detected = 1'b0;
    memory_data   = 16'h0;
    @(negedge clk);
    chk_all_zero("rstmid.idle");
    @(posedge clk); #1;
    fill_seq(16'h2000, 16'h2000, 0, 2, 1, 1'b0, "restart");

`ifndef CACHE_FILL_CRITICAL_FIRST_EN
    // Top block of the address space, with miss held high through the fill.
    fill_seq(16'hFFFA, 16'hFFF0, 0, 3, 1, 1'b1, "top_block");
`else
    // Critical word first: reads begin at 0x123A, data words 5,6,7,0..4.
    fill_seq(16'h123A, 16'h1230, 5, 4, 1, 1'b0, "critical");
    fill_seq(16'hFFFA, 16'hFFF0, 5, 3, 1, 1'b1, "top_block_crit");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
